if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 PCWrite  in  1  from hazard unit; 0 freezes PC.
REQ-005 IFIDWrite  in  1  from hazard unit; 0 freezes the IF/ID register.
REQ-006 Redirect  in  1  taken branch/jump resolved in ID.
REQ-007 RedirectPC  in  32  target address; bits [1:0] ignored and forced to 0.
REQ-008 IFIDFlush  in  1  squash IF/ID contents to a bubble.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  32  word-aligned fetch address.
REQ-011 imem_ack  in  1  read data valid this cycle; completes the request.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 IFIDPC4  out  32  registered PC+4 of the held instruction.
REQ-014 IFIDInstr  out  32  registered instruction; 32'h0 (NOP) when bubble.
REQ-015 IFIDValid  out  1  1 = real instruction, 0 = bubble.
REQ-016 FetchBusy  out  1  request outstanding and no instruction available (combinational from state).

Function
REQ-017 States SHALL be IDLE, REQ, HOLD, DROP; IDLE is entered only from reset.
REQ-018 IDLE: imem_req=0; next state REQ unconditionally (Redirect in IDLE loads PC from RedirectPC first).
REQ-019 REQ: imem_req=1, imem_addr=PC, both held stable until imem_ack.
REQ-020 REQ, ack, PCWrite=1 and IFIDWrite=1, no Redirect: IF/ID <= {PC+4, imem_rdata, 1}; PC <= PC+4; stay REQ (next address issued following cycle).
REQ-021 REQ, ack, PCWrite=0 or IFIDWrite=0: imem_rdata captured in hold buffer; PC unchanged; go HOLD.
REQ-022 REQ, no ack, IFIDWrite=1: IF/ID loads bubble (PC4 unchanged, Instr 0, Valid 0).
REQ-023 HOLD: imem_req=0; when PCWrite=1 and IFIDWrite=1, IF/ID loads buffer with PC+4, PC <= PC+4, go REQ.
REQ-024 DROP: imem_req=1 and imem_addr held at the abandoned address until ack; on ack data discarded, go REQ with the redirected PC.
REQ-025 Redirect has priority over stall and over ack: PC <= RedirectPC, IF/ID <= bubble, hold buffer discarded.
REQ-026 Redirect in REQ without ack -> DROP; in REQ with ack -> REQ (data discarded); in HOLD -> REQ; in DROP -> DROP with PC updated to latest target.
REQ-027 IFIDFlush SHALL force IF/ID to bubble on that edge regardless of IFIDWrite; flush does not alter PC or state.
REQ-028 IFIDWrite=0 and no flush/redirect: IF/ID holds every field.
REQ-029 PC+4 arithmetic is 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-030 At most one memory request outstanding at any time.

Reset
REQ-031 On rst: PC=RESET_PC, state=IDLE, IFIDPC4=0, IFIDInstr=0, IFIDValid=0, hold buffer=0, imem_req=0.
REQ-032 rst asserted mid-request: outstanding request abandoned; any imem_ack during or the cycle after reset SHALL be ignored.

Structure
REQ-033 Shared package holds the state encoding, NOP constant 32'h0 and RESET_PC default.
REQ-034 Sub-module ifid_reg implements the IF/ID register (write-enable, flush, bubble load); FSM and PC stay in if_fetch_stage.

Verification
REQ-035 Reset, ack every cycle, no stalls -> imem_addr 0,4,8,...; IFIDPC4 4,8,12 with Valid=1 one cycle after each ack.
REQ-036 Load-use stall: PCWrite=IFIDWrite=0 for 1 cycle at ack of addr 8 -> HOLD; IF/ID keeps addr-4 instruction; addr-8 word appears with IFIDPC4=12 after release, no refetch.
REQ-037 Redirect to 32'h100 while request to 0x10 unacked -> DROP; 0x10 data discarded; next imem_addr 0x100; IF/ID bubble.
REQ-038 Redirect (RedirectPC=32'h203) coincident with ack -> data discarded, next imem_addr 32'h200.
REQ-039 imem_ack delayed 3 cycles, IFIDWrite=1 -> three bubbles (Valid=0, Instr=0), FetchBusy=1 throughout.
REQ-040 rst asserted during outstanding request, ack arrives next cycle -> ack ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction fetch stage:
//   fetch_state_e    - fetch FSM state encoding
//   NOP_INSTR        - instruction word inserted for a pipeline bubble
//   DEFAULT_RESET_PC - default PC loaded on reset
//   pc_plus4()       - sequential next-PC helper (wraps modulo 2^32)
// ---------------------------------------------------------------------------
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Plain 32-bit add, so 32'hFFFF_FFFC rolls over to 32'h0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
// Instruction memory bus between the fetch stage and instruction memory.
//   imem_req   - fetch stage -> memory, request pending
//   imem_addr  - fetch stage -> memory, word-aligned fetch address
//   imem_ack   - memory -> fetch stage, read data valid, completes request
//   imem_rdata - memory -> fetch stage, instruction word
// Modports: master (fetch stage side), slave (memory side).
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_ifid.sv
// ---------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register.
//   clk, rst    - clock, synchronous active-high reset (clears to bubble)
//   write_en_i  - 0 holds every field
//   flush_i     - forces a bubble regardless of write_en_i
//   load_i      - with write_en_i: 1 loads pc4_i/instr_i as a real
//                 instruction, 0 loads a bubble
//   pc4_i       - PC+4 of the instruction being loaded
//   instr_i     - instruction word being loaded
//   pc4_o, instr_o, valid_o - registered contents
// A bubble keeps the previous PC+4 and carries a NOP with valid cleared.
// ---------------------------------------------------------------------------
module ifid_reg
    import if_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en_i,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc4_q,   pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // Flush wins over the write enable; otherwise a write either takes the
    // delivered instruction or inserts a bubble, and no write holds state.
    always_comb begin
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (write_en_i) begin
            if (load_i) begin
                pc4_d   = pc4_i;
                instr_d = instr_i;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    // Register update with synchronous reset to an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc4_q   <= 32'h0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch stage: PC register, fetch FSM, hold buffer, IF/ID reg.
//   RESET_PC   - PC loaded on reset
//   clk, rst   - clock, synchronous active-high reset
//   PCWrite    - hazard unit, 0 freezes the PC
//   IFIDWrite  - hazard unit, 0 freezes the IF/ID register
//   Redirect   - taken branch/jump resolved in ID
//   RedirectPC - redirect target, low two bits ignored
//   IFIDFlush  - squash IF/ID to a bubble
//   imem       - instruction memory bus (master side)
//   IFIDPC4, IFIDInstr, IFIDValid - IF/ID register contents
//   FetchBusy  - a request is outstanding (REQ or DROP state)
// At most one memory request is ever outstanding. DROP keeps the abandoned
// request on the bus until memory acknowledges it, so the memory never sees
// a request change underneath it.
// ---------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PCWrite,
    input  logic                     IFIDWrite,
    input  logic                     Redirect,
    input  logic [31:0]              RedirectPC,
    input  logic                     IFIDFlush,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              IFIDPC4,
    output logic [31:0]              IFIDInstr,
    output logic                     IFIDValid,
    output logic                     FetchBusy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  drop_addr_q, drop_addr_d;

    logic [31:0]  redirect_target;
    logic [31:0]  pc_next_seq;
    logic         deliver;
    logic [31:0]  deliver_instr;
    logic         ifid_flush;
    logic         redirect_pc_unused;

    assign redirect_target    = {RedirectPC[31:2], 2'b00};
    assign redirect_pc_unused = ^RedirectPC[1:0];
    assign pc_next_seq        = pc_plus4(pc_q);

    // Fetch FSM next-state and bus outputs. An instruction is "delivered"
    // to IF/ID only when both hazard enables are high and no redirect is
    // pending; a stalled ack parks the word in the hold buffer instead of
    // refetching it later. Redirect beats stalls and acks in every state.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_d         = hold_q;
        drop_addr_d    = drop_addr_q;
        deliver        = 1'b0;
        deliver_instr  = imem.imem_rdata;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (Redirect) begin
                    pc_d = redirect_target;
                end
            end

            ST_REQ: begin
                imem.imem_req = 1'b1;
                if (Redirect) begin
                    pc_d        = redirect_target;
                    drop_addr_d = pc_q;
                    state_d     = imem.imem_ack ? ST_REQ : ST_DROP;
                end else if (imem.imem_ack) begin
                    if (PCWrite && IFIDWrite) begin
                        deliver = 1'b1;
                        pc_d    = pc_next_seq;
                    end else begin
                        hold_d  = imem.imem_rdata;
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (Redirect) begin
                    pc_d    = redirect_target;
                    hold_d  = NOP_INSTR;
                    state_d = ST_REQ;
                end else if (PCWrite && IFIDWrite) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_q;
                    pc_d          = pc_next_seq;
                    state_d       = ST_REQ;
                end
            end

            ST_DROP: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = drop_addr_q;
                if (Redirect) begin
                    pc_d = redirect_target;
                end
                if (imem.imem_ack) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and buffer registers. Reset lands in IDLE, which never
    // looks at imem_ack, so a late ack from an abandoned request is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            hold_q      <= NOP_INSTR;
            drop_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    assign ifid_flush = IFIDFlush | Redirect;
    assign FetchBusy  = (state_q == ST_REQ) || (state_q == ST_DROP);

    ifid_reg u_ifid_reg (
        .clk        (clk),
        .rst        (rst),
        .write_en_i (IFIDWrite),
        .flush_i    (ifid_flush),
        .load_i     (deliver),
        .pc4_i      (pc_next_seq),
        .instr_i    (deliver_instr),
        .pc4_o      (IFIDPC4),
        .instr_o    (IFIDInstr),
        .valid_o    (IFIDValid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Self-checking bench for if_fetch_stage. The bench plays instruction
// memory (data is a fixed function of the address) and pushes the expected
// IF/ID contents into a queue whenever it lets an instruction through; the
// entry is popped and compared once the register has loaded.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_exp_t;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IFIDFlush;
    logic [31:0] IFIDPC4;
    logic [31:0] IFIDInstr;
    logic        IFIDValid;
    logic        FetchBusy;

    int checkCount = 0;
    int passCount  = 0;
    ifid_exp_t expQueue[$];

    if_fetch_stage_if imemBus ();

    // Instruction memory content: distinct from the address itself so a
    // pc4/instr swap or stale word is visible.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0], 16'hC0DE} ^ 32'h1357_9BDF;
    endfunction

    assign imemBus.imem_rdata = memWord(imemBus.imem_addr);

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCWrite    (PCWrite),
        .IFIDWrite  (IFIDWrite),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .IFIDFlush  (IFIDFlush),
        .imem       (imemBus),
        .IFIDPC4    (IFIDPC4),
        .IFIDInstr  (IFIDInstr),
        .IFIDValid  (IFIDValid),
        .FetchBusy  (FetchBusy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the rising edge happen, then settle.
    task automatic applyStimulus(input logic ack, input logic pcw,
                                 input logic ifw, input logic redir,
                                 input logic [31:0] rpc, input logic flush);
        imemBus.imem_ack = ack;
        PCWrite          = pcw;
        IFIDWrite        = ifw;
        Redirect         = redir;
        RedirectPC       = rpc;
        IFIDFlush        = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic expectInstr(input logic [31:0] addr);
        ifid_exp_t e;
        e.pc4   = addr + 32'd4;
        e.instr = memWord(addr);
        expQueue.push_back(e);
    endtask

    task automatic popInstr(input string tag);
        ifid_exp_t e;
        if (expQueue.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = expQueue.pop_front();
            checkOutput({tag, "_pc4"}, IFIDPC4, e.pc4);
            checkOutput({tag, "_instr"}, IFIDInstr, e.instr);
            checkOutput({tag, "_valid"}, {31'd0, IFIDValid}, 32'd1);
        end
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, IFIDValid}, 32'd0);
        checkOutput({tag, "_instr"}, IFIDInstr, 32'h0);
    endtask

    // One unstalled fetch: address check, ack, then IF/ID check.
    task automatic fetchOne(input string tag, input logic [31:0] addr);
        checkOutput({tag, "_req"}, {31'd0, imemBus.imem_req}, 32'd1);
        checkOutput({tag, "_addr"}, imemBus.imem_addr, addr);
        expectInstr(addr);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        popInstr(tag);
    endtask

    // Reset for two cycles with ack asserted, then one ack cycle in IDLE.
    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expQueue.delete();
    endtask

    initial begin
        rst              = 1'b1;
        PCWrite          = 1'b1;
        IFIDWrite        = 1'b1;
        Redirect         = 1'b0;
        RedirectPC       = 32'h0;
        IFIDFlush        = 1'b0;
        imemBus.imem_ack = 1'b0;

        // Reset state.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_req", {31'd0, imemBus.imem_req}, 32'd0);
        checkOutput("rst_pc4", IFIDPC4, 32'h0);
        checkBubble("rst");
        checkOutput("rst_busy", {31'd0, FetchBusy}, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkBubble("idle_ack_ignored");
        checkOutput("idle_ack_pc4", IFIDPC4, 32'h0);

        // Streaming fetch, ack every cycle.
        for (int i = 0; i < 4; i++) begin
            checkOutput("stream_busy", {31'd0, FetchBusy}, 32'd1);
            fetchOne("stream", 32'(i * 4));
        end

        // Load-use stall at the ack of address 8.
        resetDut();
        fetchOne("stall_pre", 32'h0);
        fetchOne("stall_pre", 32'h4);
        checkOutput("stall_addr", imemBus.imem_addr, 32'h8);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("hold_req", {31'd0, imemBus.imem_req}, 32'd0);
        checkOutput("hold_busy", {31'd0, FetchBusy}, 32'd0);
        checkOutput("hold_pc4", IFIDPC4, 32'h8);
        checkOutput("hold_instr", IFIDInstr, memWord(32'h4));
        expectInstr(32'h8);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        popInstr("release");
        checkOutput("release_addr", imemBus.imem_addr, 32'hC);

        // Redirect while the request to 0x10 is unacked.
        resetDut();
        for (int i = 0; i < 4; i++) fetchOne("drop_pre", 32'(i * 4));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
        checkBubble("drop_enter");
        checkOutput("drop_addr", imemBus.imem_addr, 32'h10);
        checkOutput("drop_busy", {31'd0, FetchBusy}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("drop_addr_held", imemBus.imem_addr, 32'h10);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkBubble("drop_discard");
        fetchOne("redir_target", 32'h100);

        // Redirect coincident with ack, unaligned target.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
        checkBubble("redir_ack");
        fetchOne("redir_ack_target", 32'h200);

        // Memory ack delayed three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            checkBubble("wait");
            checkOutput("wait_busy", {31'd0, FetchBusy}, 32'd1);
        end
        fetchOne("wait_done", 32'h204);

        // Flush squashes the delivered word but PC still advances.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkBubble("flush");
        fetchOne("post_flush", 32'h20C);

        // IFIDWrite low holds every IF/ID field.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("ifw0_pc4", IFIDPC4, 32'h210);
        checkOutput("ifw0_instr", IFIDInstr, memWord(32'h20C));
        checkOutput("ifw0_valid", {31'd0, IFIDValid}, 32'd1);

        // PC wrap from 0xFFFF_FFFC.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        fetchOne("wrap", 32'hFFFF_FFFC);
        fetchOne("after_wrap", 32'h0);

        // Reset during an outstanding request; ack during and after reset.
        checkOutput("midrst_addr_pre", imemBus.imem_addr, 32'h4);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        checkOutput("midrst_req", {31'd0, imemBus.imem_req}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkBubble("midrst_ack");
        fetchOne("restart", 32'h0);

        // Redirect while parked in HOLD.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
        checkBubble("hold_redir");
        fetchOne("hold_redir_target", 32'h300);

        checkOutput("sb_drained", 32'(expQueue.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
